// File: rtl/kaipokrandt_fsm_mov_multi_if.sv
// kaipokrandt_fsm_mov_multi_if: decoder/sequencer-side handshake and bus-control signals for the move FSM
interface kaipokrandt_fsm_mov_multi_if #(
  parameter int RADDR_W = 3,
  parameter int BW = 1
);
  logic start;
  logic dec_movi;
  logic dec_mov;
  logic [RADDR_W-1:0] src_addr;
  logic [RADDR_W-1:0] dst_addr;
  logic busy;
  logic done;
  logic err;
  logic imm_to_bus_en;
  logic [BW-1:0] imm_beat;
  logic src_reg_out_en;
  logic tmp_ld;
  logic tmp_to_bus_en;
  logic dst_reg_ld;
  logic [BW-1:0] dst_beat;
  logic [RADDR_W-1:0] src_sel;
  logic [RADDR_W-1:0] dst_sel;
  modport master (
    output start, dec_movi, dec_mov, src_addr, dst_addr,
    input busy, done, err, imm_to_bus_en, imm_beat, src_reg_out_en, tmp_ld,
    input tmp_to_bus_en, dst_reg_ld, dst_beat, src_sel, dst_sel
  );
  modport slave (
    input start, dec_movi, dec_mov, src_addr, dst_addr,
    output busy, done, err, imm_to_bus_en, imm_beat, src_reg_out_en, tmp_ld,
    output tmp_to_bus_en, dst_reg_ld, dst_beat, src_sel, dst_sel
  );
endinterface

// File: rtl/kaipokrandt_fsm_mov_multi.sv
// kaipokrandt_fsm_mov_multi: sequences multi-beat immediate moves and reg-to-reg moves via the temp register
module kaipokrandt_fsm_mov_multi #(
  parameter int DATA_W = 16,
  parameter int IMM_BEATS = 2,
  parameter int RADDR_W = 3,
  localparam int BW = (IMM_BEATS > 1) ? $clog2(IMM_BEATS) : 1
) (
  input logic clk,
  input logic reset,
  kaipokrandt_fsm_mov_multi_if.slave bus
);
  if (IMM_BEATS < 1 || IMM_BEATS > 8 || DATA_W < 1) begin : g_bad_param
    $error("kaipokrandt_fsm_mov_multi: IMM_BEATS must be 1..8");
  end
  typedef enum logic [2:0] {S_IDLE, S_IMM, S_RD, S_WR, S_DONE} state_t;
  localparam logic [BW-1:0] LAST = BW'(IMM_BEATS - 1);
  state_t state, next;
  logic [BW-1:0] cnt, cnt_nx;
  logic [RADDR_W-1:0] src_q, dst_q;
  logic err_q, err_nx, ld;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      src_q <= '0;
      dst_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= next;
      cnt <= cnt_nx;
      err_q <= err_nx;
      if (ld) begin
        src_q <= bus.src_addr;
        dst_q <= bus.dst_addr;
      end
    end
  end
  always_comb begin
    next = state;
    cnt_nx = cnt;
    err_nx = 1'b0;
    ld = 1'b0;
    case (state)
      S_IDLE: if (bus.start) begin
        if (bus.dec_movi && !bus.dec_mov) begin
          next = S_IMM;
          cnt_nx = '0;
          ld = 1'b1;
        end else if (bus.dec_mov && !bus.dec_movi) begin
          next = S_RD;
          ld = 1'b1;
        end else err_nx = 1'b1;
      end
      S_IMM: if (cnt == LAST) next = S_DONE; else cnt_nx = cnt + 1'b1;
      S_RD: next = S_WR;
      S_WR: next = S_DONE;
      S_DONE: next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end
  // Beat indices read zero outside S_IMM so S_WR always targets slice 0
  always_comb begin
    bus.busy = state == S_IMM || state == S_RD || state == S_WR;
    bus.done = state == S_DONE;
    bus.err = err_q;
    bus.imm_to_bus_en = state == S_IMM;
    bus.src_reg_out_en = state == S_RD;
    bus.tmp_ld = state == S_RD;
    bus.tmp_to_bus_en = state == S_WR;
    bus.dst_reg_ld = state == S_IMM || state == S_WR;
    bus.imm_beat = state == S_IMM ? cnt : '0;
    bus.dst_beat = state == S_IMM ? cnt : '0;
    bus.src_sel = src_q;
    bus.dst_sel = dst_q;
  end
endmodule

// File: tb/tb_kaipokrandt_fsm_mov_multi.sv
// tb_kaipokrandt_fsm_mov_multi: directed checks on IMM_BEATS=1,2,4 instances of the move FSM
module tb_kaipokrandt_fsm_mov_multi;
  localparam logic [7:0] IMMC = 8'b1001_0001;
  localparam logic [7:0] RDC = 8'b1000_1100;
  localparam logic [7:0] WRC = 8'b1000_0011;
  localparam logic [7:0] DNC = 8'b0100_0000;
  localparam logic [7:0] ERC = 8'b0010_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vec = 0;
  int bad = 0;
  always #5 clk = ~clk;
  kaipokrandt_fsm_mov_multi_if #(.RADDR_W(3), .BW(1)) i1 ();
  kaipokrandt_fsm_mov_multi_if #(.RADDR_W(3), .BW(1)) i2 ();
  kaipokrandt_fsm_mov_multi_if #(.RADDR_W(3), .BW(2)) i4 ();
  kaipokrandt_fsm_mov_multi #(.DATA_W(16), .IMM_BEATS(1), .RADDR_W(3)) u1 (.clk(clk), .reset(reset), .bus(i1));
  kaipokrandt_fsm_mov_multi #(.DATA_W(16), .IMM_BEATS(2), .RADDR_W(3)) u2 (.clk(clk), .reset(reset), .bus(i2));
  kaipokrandt_fsm_mov_multi #(.DATA_W(16), .IMM_BEATS(4), .RADDR_W(3)) u4 (.clk(clk), .reset(reset), .bus(i4));
  logic [7:0] f1, f2, f4;
  assign f1 = {i1.busy, i1.done, i1.err, i1.imm_to_bus_en, i1.src_reg_out_en, i1.tmp_ld, i1.tmp_to_bus_en, i1.dst_reg_ld};
  assign f2 = {i2.busy, i2.done, i2.err, i2.imm_to_bus_en, i2.src_reg_out_en, i2.tmp_ld, i2.tmp_to_bus_en, i2.dst_reg_ld};
  assign f4 = {i4.busy, i4.done, i4.err, i4.imm_to_bus_en, i4.src_reg_out_en, i4.tmp_ld, i4.tmp_to_bus_en, i4.dst_reg_ld};
  task automatic test_reset();
    #1;
    vec++; if ({f1, f2, f4} !== 24'h0) begin bad++; $display("FAIL reset_flags got %h want 000000", {f1, f2, f4}); end
    vec++; if ({i2.src_sel, i2.dst_sel, i4.src_sel, i4.dst_sel} !== 12'h0) begin bad++; $display("FAIL reset_sel got %h want 000", {i2.src_sel, i2.dst_sel, i4.src_sel, i4.dst_sel}); end
    vec++; if ({i2.imm_beat, i2.dst_beat, i4.imm_beat, i4.dst_beat} !== 6'h0) begin bad++; $display("FAIL reset_beat got %h want 00", {i2.imm_beat, i2.dst_beat, i4.imm_beat, i4.dst_beat}); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_movi2();
    logic [7:0] e;
    @(negedge clk);
    i2.start = 1; i2.dec_movi = 1; i2.dec_mov = 0; i2.src_addr = 3'd1; i2.dst_addr = 3'd5;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      i2.start = 0;
      e = c <= 2 ? IMMC : c == 3 ? DNC : 8'h00;
      vec++; if (f2 !== e) begin bad++; $display("FAIL movi2_flags c%0d got %b want %b", c, f2, e); end
      if (c <= 2) begin
        vec++; if (i2.imm_beat !== 1'(c - 1) || i2.dst_beat !== 1'(c - 1)) begin bad++; $display("FAIL movi2_beat c%0d got %0d/%0d want %0d", c, i2.imm_beat, i2.dst_beat, c - 1); end
      end
      vec++; if (i2.dst_sel !== 3'd5 || i2.src_sel !== 3'd1) begin bad++; $display("FAIL movi2_sel c%0d got %0d/%0d want 1/5", c, i2.src_sel, i2.dst_sel); end
    end
  endtask
  task automatic test_movi1();
    logic [7:0] e;
    @(negedge clk);
    i1.start = 1; i1.dec_movi = 1; i1.dec_mov = 0; i1.src_addr = 3'd0; i1.dst_addr = 3'd3;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      i1.start = 0;
      e = c == 1 ? IMMC : c == 2 ? DNC : 8'h00;
      vec++; if (f1 !== e) begin bad++; $display("FAIL movi1_flags c%0d got %b want %b", c, f1, e); end
      vec++; if (i1.imm_beat !== 1'b0 || i1.dst_sel !== 3'd3) begin bad++; $display("FAIL movi1_beat_sel c%0d got %0d/%0d want 0/3", c, i1.imm_beat, i1.dst_sel); end
    end
  endtask
  task automatic test_mov();
    logic [7:0] e;
    @(negedge clk);
    i2.start = 1; i2.dec_movi = 0; i2.dec_mov = 1; i2.src_addr = 3'd2; i2.dst_addr = 3'd6;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      i2.start = 0;
      e = c == 1 ? RDC : c == 2 ? WRC : c == 3 ? DNC : 8'h00;
      vec++; if (f2 !== e) begin bad++; $display("FAIL mov_flags c%0d got %b want %b", c, f2, e); end
      vec++; if ($countones({i2.imm_to_bus_en, i2.src_reg_out_en, i2.tmp_to_bus_en}) > 1) begin bad++; $display("FAIL mov_excl c%0d got %b want at most one", c, {i2.imm_to_bus_en, i2.src_reg_out_en, i2.tmp_to_bus_en}); end
      vec++; if (i2.src_sel !== 3'd2 || i2.dst_sel !== 3'd6 || i2.dst_beat !== 1'b0) begin bad++; $display("FAIL mov_sel c%0d got %0d/%0d/%0d want 2/6/0", c, i2.src_sel, i2.dst_sel, i2.dst_beat); end
    end
  endtask
  task automatic test_err();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i2.start = 1; i2.dec_movi = k == 0; i2.dec_mov = k == 0; i2.src_addr = 3'd7; i2.dst_addr = 3'd7;
      @(negedge clk);
      i2.start = 0;
      vec++; if (f2 !== ERC) begin bad++; $display("FAIL err_pulse k%0d got %b want %b", k, f2, ERC); end
      vec++; if (i2.src_sel !== 3'd2 || i2.dst_sel !== 3'd6) begin bad++; $display("FAIL err_sel k%0d got %0d/%0d want 2/6", k, i2.src_sel, i2.dst_sel); end
      @(negedge clk);
      vec++; if (f2 !== 8'h00) begin bad++; $display("FAIL err_clear k%0d got %b want 00000000", k, f2); end
    end
  endtask
  task automatic test_ignore();
    logic [7:0] e;
    @(negedge clk);
    i2.start = 1; i2.dec_movi = 1; i2.dec_mov = 0; i2.src_addr = 3'd1; i2.dst_addr = 3'd5;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      i2.start = c <= 3; i2.dec_movi = 0; i2.dec_mov = 1; i2.src_addr = 3'd7; i2.dst_addr = 3'd3;
      e = c <= 2 ? IMMC : c == 3 ? DNC : 8'h00;
      vec++; if (f2 !== e) begin bad++; $display("FAIL ignore_flags c%0d got %b want %b", c, f2, e); end
      vec++; if (i2.src_sel !== 3'd1 || i2.dst_sel !== 3'd5) begin bad++; $display("FAIL ignore_sel c%0d got %0d/%0d want 1/5", c, i2.src_sel, i2.dst_sel); end
    end
    i2.start = 0; i2.dec_mov = 0;
    @(negedge clk);
    vec++; if (f2 !== 8'h00) begin bad++; $display("FAIL ignore_idle got %b want 00000000", f2); end
  endtask
  task automatic test_async_reset();
    logic [7:0] e;
    @(negedge clk);
    i4.start = 1; i4.dec_movi = 1; i4.dec_mov = 0; i4.src_addr = 3'd2; i4.dst_addr = 3'd4;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      i4.start = 0;
      vec++; if (f4 !== IMMC || i4.imm_beat !== 2'(c - 1)) begin bad++; $display("FAIL ar_pre c%0d got %b/%0d want %b/%0d", c, f4, i4.imm_beat, IMMC, c - 1); end
    end
    #2 reset = 1'b1;
    #1;
    vec++; if (f4 !== 8'h00 || i4.imm_beat !== 2'd0 || i4.dst_beat !== 2'd0) begin bad++; $display("FAIL ar_now got %b/%0d/%0d want 0/0/0", f4, i4.imm_beat, i4.dst_beat); end
    vec++; if (i4.src_sel !== 3'd0 || i4.dst_sel !== 3'd0) begin bad++; $display("FAIL ar_sel got %0d/%0d want 0/0", i4.src_sel, i4.dst_sel); end
    @(negedge clk);
    vec++; if (f4 !== 8'h00) begin bad++; $display("FAIL ar_nodone got %b want 00000000", f4); end
    reset = 1'b0;
    @(negedge clk);
    i4.start = 1; i4.dst_addr = 3'd6;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      i4.start = 0;
      e = c <= 4 ? IMMC : c == 5 ? DNC : 8'h00;
      vec++; if (f4 !== e) begin bad++; $display("FAIL ar_fresh c%0d got %b want %b", c, f4, e); end
      if (c <= 4) begin
        vec++; if (i4.imm_beat !== 2'(c - 1) || i4.dst_beat !== 2'(c - 1) || i4.dst_sel !== 3'd6) begin bad++; $display("FAIL ar_beat c%0d got %0d/%0d/%0d want %0d/6", c, i4.imm_beat, i4.dst_beat, i4.dst_sel, c - 1); end
      end
    end
  endtask
  initial begin
    {i1.start, i1.dec_movi, i1.dec_mov, i1.src_addr, i1.dst_addr} = '0;
    {i2.start, i2.dec_movi, i2.dec_mov, i2.src_addr, i2.dst_addr} = '0;
    {i4.start, i4.dec_movi, i4.dec_mov, i4.src_addr, i4.dst_addr} = '0;
    test_reset();
    test_movi2();
    test_movi1();
    test_mov();
    test_err();
    test_ignore();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
